// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
//
// Purpose:
//   Execute-stage ALU. It takes the 4-bit ALU control code and two operands
//   over a valid/ready handshake. It returns a registered result together with
//   a one-cycle out_valid pulse.
//   - Logic, arithmetic and compare operations complete one cycle after
//     they are accepted.
//   - Shifts normally run iteratively, moving one bit per cycle, so a
//     shift by k has a latency of k+1.
//   - When MCALU_BARREL_SHIFT_EN is defined, shifts are computed
//     combinationally at acceptance and also have a latency of 1. In that
//     build in_ready is constantly 1.
//
// Configuration macro: MCALU_BARREL_SHIFT_EN
//
// Ports:
//   clk        in   1           rising-edge clock
//   reset_n    in   1           asynchronous active-low reset
//   flush      in   1           synchronous abort of any in-flight operation
//   in_valid   in   1           operation/operands presented
//   in_ready   out  1           block can accept this cycle
//   operation  in   4           ALU control code
//   srca       in   DATA_WIDTH  operand A
//   srcb       in   DATA_WIDTH  operand B / shift amount (low SHAMT_W bits)
//   out_valid  out  1           one-cycle pulse, result is new this cycle
//   result     out  DATA_WIDTH  registered result, held between completions
//   zero       out  1           result == 0
// -----------------------------------------------------------------------------
module multicycle_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            operation,
    input  logic [DATA_WIDTH-1:0] srca,
    input  logic [DATA_WIDTH-1:0] srcb,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLL = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;

    // Non-shift operations. Unassigned codes, including the shift codes,
    // fall back to ADD. Callers handle the shift codes separately.
    function automatic logic [DATA_WIDTH-1:0] alu_basic(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_SUB:  r = a - b;
            OP_ADD:  r = a + b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_EQ:   r = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
            default: r = a + b;
        endcase
        return r;
    endfunction

    logic               w_is_shift;
    logic               w_accept;
    logic [SHAMT_W-1:0] w_shamt;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_out_valid;

    assign w_is_shift = (operation == OP_SLL) || (operation == OP_SRL) ||
                        (operation == OP_SRA);
    assign w_shamt    = srcb[SHAMT_W-1:0];
    // Flush wins over a simultaneous request.
    assign w_accept   = in_valid & in_ready & ~flush;

    assign result    = r_result;
    assign out_valid = r_out_valid;
    assign zero      = (r_result == {DATA_WIDTH{1'b0}});

`ifdef MCALU_BARREL_SHIFT_EN

    logic [DATA_WIDTH-1:0] w_result_nxt;

    assign in_ready = 1'b1;

    // Full single-cycle result, including combinational shifts.
    always_comb begin
        w_result_nxt = alu_basic(operation, srca, srcb);
        case (operation)
            OP_SLL:  w_result_nxt = srca << w_shamt;
            OP_SRL:  w_result_nxt = srca >> w_shamt;
            OP_SRA:  w_result_nxt = $unsigned($signed(srca) >>> w_shamt);
            default: w_result_nxt = alu_basic(operation, srca, srcb);
        endcase
    end

    // Result register and completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result    <= {DATA_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_result <= w_result_nxt;
            end else begin
                r_result <= r_result;
            end
        end
    end

`else

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_opnd;
    logic [SHAMT_W-1:0]    r_cnt;
    logic [1:0]            r_dir;       // operation[1:0]: 01 SLL, 10 SRL, 11 SRA
    logic                  w_start;
    logic                  w_done;
    logic                  w_single;
    logic [DATA_WIDTH-1:0] w_single_val;
    logic [DATA_WIDTH-1:0] w_shift1;

    assign in_ready = (r_state == ST_IDLE);

    // A shift by zero completes like any single-cycle operation.
    assign w_single     = w_accept & ~(w_is_shift & (w_shamt != {SHAMT_W{1'b0}}));
    assign w_single_val = w_is_shift ? srca : alu_basic(operation, srca, srcb);

    // One-bit step of the operand register in the latched direction.
    always_comb begin
        w_shift1 = r_opnd;
        case (r_dir)
            2'b01:   w_shift1 = {r_opnd[DATA_WIDTH-2:0], 1'b0};
            2'b10:   w_shift1 = {1'b0, r_opnd[DATA_WIDTH-1:1]};
            2'b11:   w_shift1 = {r_opnd[DATA_WIDTH-1], r_opnd[DATA_WIDTH-1:1]};
            default: w_shift1 = r_opnd;
        endcase
    end

    // Next-state logic and the start/done strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_shift && (w_shamt != {SHAMT_W{1'b0}})) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == SHAMT_W'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift operand, counter, direction, result and completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opnd      <= {DATA_WIDTH{1'b0}};
            r_cnt       <= {SHAMT_W{1'b0}};
            r_dir       <= 2'b00;
            r_result    <= {DATA_WIDTH{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_single | w_done;

            if (w_single) begin
                r_result <= w_single_val;
            end else if (w_done) begin
                r_result <= w_shift1;
            end else begin
                r_result <= r_result;
            end

            if (w_start) begin
                r_opnd <= srca;
                r_cnt  <= w_shamt;
                r_dir  <= operation[1:0];
            end else if ((r_state == ST_SHIFT) && flush) begin
                r_cnt  <= {SHAMT_W{1'b0}};
            end else if (r_state == ST_SHIFT) begin
                r_opnd <= w_shift1;
                r_cnt  <= r_cnt - SHAMT_W'(1);
            end else begin
                r_opnd <= r_opnd;
                r_cnt  <= r_cnt;
            end
        end
    end

`endif

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  operation;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;

    int n_vec;
    int n_bad;

    multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .srca      (srca),
        .srcb      (srcb),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_latency(input int k);
`ifdef MCALU_BARREL_SHIFT_EN
        return 1;
`else
        return (k == 0) ? 1 : k + 1;
`endif
    endfunction

    // Issue one shift, scramble the inputs while it runs, and measure the
    // latency and in_ready-low cycles. Returns in the out_valid cycle.
    task automatic do_shift(input string name, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        int lat;
        int low;
        int k;
        k = int'(b[4:0]);
        operation = op; srca = a; srcb = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        operation = 4'b0000; srca = 32'hDEAD_BEEF; srcb = 32'h0000_0003;
        lat = 1;
        low = 0;
        while (!out_valid && lat < 64) begin
            if (!in_ready) low++;
            tick();
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_latency(k)));
        check({name, " result"}, result, exp);
        check({name, " ready-low cycles"}, 32'(low), 32'(exp_latency(k) - 1));
        check({name, " ready at done"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        flush = 1'b0; in_valid = 1'b0; operation = 4'b0000;
        srca = 32'd0; srcb = 32'd0;

        vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1]  = '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000};
        vecs[2]  = '{4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[3]  = '{4'b1000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000};
        vecs[4]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[5]  = '{4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vecs[6]  = '{4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[7]  = '{4'b0101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[8]  = '{4'b1000, 32'h0000_0007, 32'h0000_0007, 32'h0000_0001};
        vecs[9]  = '{4'b0110, 32'h0000_000A, 32'h0000_0014, 32'h0000_001E};
        vecs[10] = '{4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[11] = '{4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[12] = '{4'b1001, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001};
        vecs[13] = '{4'b1011, 32'h8000_0000, 32'h0000_0040, 32'h8000_0000};
        vecs[14] = '{4'b0111, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123};

        // Reset state, checked while reset is asserted.
        reset_n = 1'b0;
        #2;
        check("reset result", result, 32'd0);
        check("reset zero", {31'd0, zero}, 32'd1);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        #10;
        reset_n = 1'b1;
        tick();

        // Back-to-back single-cycle ops: one pulse per cycle.
        for (int i = 0; i < 15; i++) begin
            operation = vecs[i].op; srca = vecs[i].a; srcb = vecs[i].b;
            in_valid = 1'b1;
            tick();
            check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d result", i), result, vecs[i].exp);
            check($sformatf("vec%0d zero", i), {31'd0, zero},
                  {31'd0, (vecs[i].exp == 32'd0)});
        end
        in_valid = 1'b0;
        tick();
        check("idle no pulse", {31'd0, out_valid}, 32'd0);

        // Iterative shifts.
        do_shift("SRA4", 4'b1011, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        tick();
        check("pulse width", {31'd0, out_valid}, 32'd0);
        do_shift("SRL4", 4'b1010, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
        do_shift("SLL31", 4'b1001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
        do_shift("SRA31", 4'b1011, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF);

        // New op accepted in the same cycle as the shift completion pulse.
        do_shift("SRL1", 4'b1010, 32'h0000_0010, 32'h0000_0001, 32'h0000_0008);
        operation = 4'b0010; srca = 32'd2; srcb = 32'd3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept at done pulse", {31'd0, out_valid}, 32'd1);
        check("accept at done result", result, 32'd5);

        // Flush together with a request in IDLE: not accepted.
        operation = 4'b0010; srca = 32'd10; srcb = 32'd10; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush idle no pulse", {31'd0, out_valid}, 32'd0);
        tick();
        check("flush idle result", result, 32'd5);

`ifndef MCALU_BARREL_SHIFT_EN
        // Flush mid-shift (SLL by 8, flush sampled at edge N+3).
        operation = 4'b1001; srca = 32'd3; srcb = 32'd8; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("flush shift busy", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush shift ready", {31'd0, in_ready}, 32'd1);
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 12; c++) begin
                if (out_valid) pulses++;
                tick();
            end
            check("flush shift pulses", 32'(pulses), 32'd0);
        end
        check("flush shift result", result, 32'd5);

        // Reset pulsed mid-shift.
        operation = 4'b1001; srca = 32'd3; srcb = 32'd8; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check("mid reset result", result, 32'd0);
        check("mid reset ready", {31'd0, in_ready}, 32'd1);
        #2;
        reset_n = 1'b1;
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 12; c++) begin
                tick();
                if (out_valid) pulses++;
            end
            check("mid reset pulses", 32'(pulses), 32'd0);
        end
        check("mid reset result held", result, 32'd0);
        check("mid reset zero", {31'd0, zero}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

- Execute-stage ALU that consumes the 4-bit `operation` code produced by the ALU control decoder, plus two operands.
- Returns a registered result and a zero flag over a valid/ready handshake.
- Single-cycle ops complete in 1 cycle. Shifts run iteratively, 1 bit per cycle, unless the barrel shifter is compiled in.
- Sits between the decode/ALU-control stage and the memory/writeback stage. The pipeline stalls on `in_ready` low.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: operand/result width. Power of 2, at least 8.
- `SHAMT_W`, default `$clog2(DATA_WIDTH)`: shift-amount width, taken from `srcb[SHAMT_W-1:0]`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of any in-flight operation.
- `in_valid`  in  1  operands and operation are presented.
- `in_ready`  out  1  block can accept this cycle.
- `operation`  in  4  ALU control code.
- `srca`  in  DATA_WIDTH  operand A.
- `srcb`  in  DATA_WIDTH  operand B / shift amount.
- `out_valid`  out  1  one-cycle pulse; `result` is new this cycle.
- `result`  out  DATA_WIDTH  registered result, held until the next completion.
- `zero`  out  1  `result == 0`, combinational from the result register.

## Operation

- Codes:
  - 0000 AND
  - 0001 SUB (A−B)
  - 0010 ADD
  - 0011 OR
  - 0100 XOR
  - 0101 SLT (signed; result 1 or 0, zero-extended)
  - 1000 EQ (result 1 if A==B, else 0)
  - 1001 SLL
  - 1010 SRL
  - 1011 SRA
  - All other codes: ADD.
- Arithmetic wraps modulo 2^DATA_WIDTH. There are no overflow or carry outputs.
- Shifts use only `srcb[SHAMT_W-1:0]`; upper bits are ignored. SRA replicates `srca[DATA_WIDTH-1]`.
- FSM has two states, IDLE and SHIFT. `in_ready = (state == IDLE)`.
- IDLE, handshake (`in_valid & in_ready & ~flush`):
  - Non-shift op, or shift with shamt 0: `result` is loaded next edge, `out_valid` pulses, state stays IDLE.
  - Shift with shamt k > 0: operand register ← `srca`, counter ← k, op latched, go to SHIFT.
- SHIFT:
  - Each cycle: shift operand register 1 bit in the latched direction and decrement the counter.
  - On the edge where the counter goes 1 → 0: `result` ← shifted value, `out_valid` pulses, go to IDLE.
- `flush` in SHIFT: return to IDLE next edge. No `out_valid`; `result` keeps its prior value.
- `flush` with `in_valid` in IDLE: the operation is not accepted and no `out_valid` is produced. Flush wins.
- Inputs are sampled only at handshake. Changing `operation`/`srca`/`srcb` during SHIFT has no effect.

## Timing

- Reset values (asynchronous, while `reset_n` = 0):
  - state IDLE
  - `in_ready` 1
  - `out_valid` 0
  - `result` 0
  - `zero` 1
  - counter 0
- Reset mid-SHIFT aborts immediately. No completion pulse follows release.
- Latency, handshake at edge N:
  - Non-shift, or shamt 0: `out_valid` in cycle N+1.
  - Iterative shift by k: `out_valid` in cycle N+k+1. `in_ready` is low for cycles N+1 .. N+k and high again in cycle N+k+1, the same cycle as `out_valid`.
- Throughput: one non-shift op per cycle back-to-back. A new op may be accepted in the same cycle the previous shift's `out_valid` is high.
- `out_valid` is exactly one cycle wide. There is no downstream backpressure: the consumer must capture `result` on the pulse.

## Configuration

- `MCALU_BARREL_SHIFT_EN` defined:
  - Shifts are computed combinationally at handshake with 1-cycle latency, identical to the other ops.
  - The SHIFT state and counter are not instantiated; `in_ready` is constantly 1 after reset.
- `MCALU_BARREL_SHIFT_EN` not defined: iterative shift as described, latency k+1.
- Results are bit-identical in both builds; only timing differs.

## Test plan

- Reset then idle: `reset_n` low → `result`=0, `zero`=1, `in_ready`=1, `out_valid`=0.
- Back-to-back ALU ops:
  - ADD 0x7FFFFFFF+1 → `result` 0x80000000, next cycle.
  - SUB 5−5 → `result` 0, `zero`=1.
  - SLT −1 < 1 → `result` 1.
  - EQ 3,4 → `result` 0.
  - Expect one `out_valid` per cycle.
- Iterative SRA: A=0x80000000, B=0x00000024 (shamt 4) → `in_ready` low 4 cycles, `out_valid` at N+5, `result`=0xF8000000. SRL same inputs → 0x08000000.
- Shamt 0 and upper-bit masking: SLL A=0x1, B=0x20 → 1-cycle latency, `result`=0x1.
- Flush and reset mid-shift:
  - SLL by 8, `flush` at N+3 → no `out_valid`, `in_ready` high at N+4, `result` unchanged.
  - Repeat with `reset_n` pulsed low at N+3 → `result`=0, no pulse after release.
- Macro build: with `MCALU_BARREL_SHIFT_EN`, SRA by 31 of 0x80000000 → `result` 0xFFFFFFFF at N+1, `in_ready` never low.
